// File: rtl/pll_cfg_sequencer_if.sv
// Sequencer <-> environment bundle: config-word fetch, 3-wire synthesizer bus, lock input and status.
// master = sequencer side, slave = mapper / synthesizer / host side.
interface pll_cfg_sequencer_if;
   logic        start;
   logic [2:0]  word_idx;
   logic [31:0] word_data;
   logic        pll_lock;
   logic        pll_sclk;
   logic        pll_sdata;
   logic        pll_le;
   logic        busy;
   logic        done;
   logic        fail;
   logic        lock_ok;
   logic [1:0]  retry_cnt;

   modport master (
      input  start, word_data, pll_lock,
      output word_idx, pll_sclk, pll_sdata, pll_le, busy, done, fail, lock_ok, retry_cnt
   );

   modport slave (
      output start, word_data, pll_lock,
      input  word_idx, pll_sclk, pll_sdata, pll_le, busy, done, fail, lock_ok, retry_cnt
   );
endinterface

// File: rtl/pll_cfg_sequencer.sv
// Loads NUM_WORDS config words MSB-first onto a 3-wire synthesizer bus, then waits for lock with retries.
// PLL_CFG_LOCK_MONITOR_EN: after a success, 256 clk of lost lock in IDLE triggers an automatic reload.
module pll_cfg_sequencer #(
   parameter int CLK_DIV   = 4,
   parameter int NUM_WORDS = 6,
   parameter int LOCK_WAIT = 100000,
   parameter int MAX_RETRY = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   pll_cfg_sequencer_if.master  bus
);
   localparam int          DW        = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [23:0] LW_MAX    = 24'(LOCK_WAIT - 1);
   localparam logic [2:0]  IDX_MAX   = 3'(NUM_WORDS - 1);
   localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_SHIFT, S_LATCH, S_GAP, S_WAIT_LOCK, S_DONE, S_FAIL
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [2:0]    r_word_idx, w_word_idx_nxt;
   logic [31:0]   r_shift, w_shift_nxt;
   logic [DW-1:0] r_div, w_div_nxt;
   logic [4:0]    r_bit, w_bit_nxt;
   logic          r_sclk, w_sclk_nxt;
   logic          r_sdata, w_sdata_nxt;
   logic          r_le, w_le_nxt;
   logic          r_busy, w_busy_nxt;
   logic          r_done, w_done_nxt;
   logic          r_fail, w_fail_nxt;
   logic          r_lock_ok, w_lock_ok_nxt;
   logic [1:0]    r_retry, w_retry_nxt;
   logic          r_pending, w_pending_nxt;
   logic          r_success, w_success_nxt;
   logic [23:0]   r_timer, w_timer_nxt;
   logic [3:0]    r_lock_cnt, w_lock_cnt_nxt;
   logic [1:0]    r_sync;
   logic          w_lock_s;
   logic          w_div_end;
   logic          w_restart;
   logic          w_auto_start;

   assign w_lock_s  = r_sync[1];
   assign w_div_end = (r_div == DIV_MAX);

`ifdef PLL_CFG_LOCK_MONITOR_EN
   logic [7:0] r_loss_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         r_loss_cnt <= '0;
      else if (r_state == S_IDLE && r_success && !w_lock_s)
         r_loss_cnt <= r_loss_cnt + 8'd1;
      else
         r_loss_cnt <= '0;
   end

   assign w_auto_start = (r_state == S_IDLE) && r_success && !w_lock_s && (r_loss_cnt == 8'd255);
`else
   assign w_auto_start = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_word_idx <= '0;
         r_shift    <= '0;
         r_div      <= '0;
         r_bit      <= '0;
         r_sclk     <= 1'b0;
         r_sdata    <= 1'b0;
         r_le       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_fail     <= 1'b0;
         r_lock_ok  <= 1'b0;
         r_retry    <= '0;
         r_pending  <= 1'b0;
         r_success  <= 1'b0;
         r_timer    <= '0;
         r_lock_cnt <= '0;
         r_sync     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_word_idx <= w_word_idx_nxt;
         r_shift    <= w_shift_nxt;
         r_div      <= w_div_nxt;
         r_bit      <= w_bit_nxt;
         r_sclk     <= w_sclk_nxt;
         r_sdata    <= w_sdata_nxt;
         r_le       <= w_le_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_fail     <= w_fail_nxt;
         r_lock_ok  <= w_lock_ok_nxt;
         r_retry    <= w_retry_nxt;
         r_pending  <= w_pending_nxt;
         r_success  <= w_success_nxt;
         r_timer    <= w_timer_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
         r_sync     <= {r_sync[0], bus.pll_lock};
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_word_idx_nxt = r_word_idx;
      w_shift_nxt    = r_shift;
      w_div_nxt      = r_div;
      w_bit_nxt      = r_bit;
      w_sclk_nxt     = r_sclk;
      w_sdata_nxt    = r_sdata;
      w_le_nxt       = r_le;
      w_done_nxt     = 1'b0;
      w_fail_nxt     = r_fail;
      w_retry_nxt    = r_retry;
      w_pending_nxt  = r_pending;
      w_success_nxt  = r_success;
      w_timer_nxt    = r_timer;
      w_lock_cnt_nxt = r_lock_cnt;
      w_restart      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.start || w_auto_start) w_restart = 1'b1;
         end
         S_FETCH: begin
            w_shift_nxt = bus.word_data;
            w_sdata_nxt = bus.word_data[31];
            w_sclk_nxt  = 1'b0;
            w_div_nxt   = '0;
            w_bit_nxt   = '0;
            w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            if (!w_div_end) begin
               w_div_nxt = r_div + DW'(1);
            end else begin
               w_div_nxt = '0;
               if (!r_sclk) begin
                  w_sclk_nxt = 1'b1;
               end else begin
                  // Falling edge: advance the shifter and present the next bit.
                  w_sclk_nxt  = 1'b0;
                  w_shift_nxt = {r_shift[30:0], 1'b0};
                  w_bit_nxt   = r_bit + 5'd1;
                  if (r_bit == 5'd31) begin
                     w_sdata_nxt = 1'b0;
                     w_le_nxt    = 1'b1;
                     w_state_nxt = S_LATCH;
                  end else begin
                     w_sdata_nxt = r_shift[30];
                  end
               end
            end
         end
         S_LATCH: begin
            w_div_nxt = r_div + DW'(1);
            if (w_div_end) begin
               w_div_nxt   = '0;
               w_le_nxt    = 1'b0;
               w_state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            w_div_nxt = r_div + DW'(1);
            if (w_div_end) begin
               w_div_nxt = '0;
               if (r_word_idx < IDX_MAX) begin
                  w_word_idx_nxt = r_word_idx + 3'd1;
                  w_state_nxt    = S_FETCH;
               end else begin
                  w_timer_nxt    = '0;
                  w_lock_cnt_nxt = '0;
                  w_state_nxt    = S_WAIT_LOCK;
               end
            end
         end
         S_WAIT_LOCK: begin
            w_lock_cnt_nxt = w_lock_s ? r_lock_cnt + 4'd1 : 4'd0;
            w_timer_nxt    = r_timer + 24'd1;
            // Lock success wins over a timeout landing on the same clk.
            if (w_lock_s && r_lock_cnt == 4'd15) begin
               w_done_nxt    = 1'b1;
               w_success_nxt = 1'b1;
               w_state_nxt   = S_DONE;
            end else if (r_timer == LW_MAX) begin
               if (r_retry < RETRY_MAX) begin
                  w_retry_nxt    = r_retry + 2'd1;
                  w_word_idx_nxt = '0;
                  w_state_nxt    = S_FETCH;
               end else begin
                  w_fail_nxt  = 1'b1;
                  w_state_nxt = S_FAIL;
               end
            end
         end
         S_DONE, S_FAIL: begin
            w_pending_nxt = 1'b0;
            if (bus.start || r_pending) w_restart = 1'b1;
            else                        w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_restart) begin
         w_state_nxt    = S_FETCH;
         w_word_idx_nxt = '0;
         w_retry_nxt    = '0;
         w_fail_nxt     = 1'b0;
         w_success_nxt  = 1'b0;
      end

      if (bus.start && !(r_state inside {S_IDLE, S_DONE, S_FAIL}))
         w_pending_nxt = 1'b1;

      w_busy_nxt    = !(w_state_nxt inside {S_IDLE, S_DONE, S_FAIL});
      w_lock_ok_nxt = w_lock_s &&
                      (w_state_nxt == S_DONE || (w_state_nxt == S_IDLE && w_success_nxt));
   end

   assign bus.word_idx  = r_word_idx;
   assign bus.pll_sclk  = r_sclk;
   assign bus.pll_sdata = r_sdata;
   assign bus.pll_le    = r_le;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.fail      = r_fail;
   assign bus.lock_ok   = r_lock_ok;
   assign bus.retry_cnt = r_retry;
endmodule
